acc_core_p: RTL and testbench
=============================

Name: acc_core_p

Overview:
Parametrised successor to the team's 8-bit accumulator processor core, with memories moved outside the block. It is a multi-cycle accumulator machine with configurable data width, PC width, register count and data-memory depth. New over the previous generation: conditional jumps, a hardware call/return stack, a HALT state, and ports for synchronous external program and data memories. It sits at the top of a SoC tile and drives external PM/DM macros.

Parameters:
DATA_W, 8, accumulator/register/data-memory word width
PC_W, 6, program counter width; PC wraps modulo 2^PC_W
NREGS, 8, register-file entries (power of 2, >=2); R[NREGS-1] is the read-only input port
DM_AW, 4, data-memory address width
STACK_DEPTH, 4, call/return stack entries

Ports:
clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-high reset
pm_addr  out  PC_W  program-memory address, synchronous 1-cycle read
pm_ins  in  4+OPND_W  instruction word; OPND_W = max(DATA_W, PC_W)
dm_addr  out  DM_AW  data-memory address
dm_wdata  out  DATA_W  write data, always equal to A
dm_we  out  1  data-memory write strobe
dm_rdata  in  DATA_W  read data, 1-cycle synchronous read
in_port  in  DATA_W  value returned when R[NREGS-1] is read
halted  out  1  core is in HALT
stack_err  out  1  sticky overflow/underflow flag
pc_o  out  PC_W  debug PC
accu_o  out  DATA_W  debug accumulator

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: PC=0, A=0, C=0, all regs=0, SP=0, state=FETCH, dm_we=0, halted=0, stack_err=0. Reset wins over every other event, including reset asserted mid-instruction or while in HALT.
- Instruction fields: ins[3+OPND_W:OPND_W]=opcode; opnd=ins[OPND_W-1:0]. Register index = opnd[clog2(NREGS)-1:0]. DM address = opnd[DM_AW-1:0]. Immediate = opnd[DATA_W-1:0]. Target = opnd[PC_W-1:0].
- FSM states: FETCH, EXEC, MEMRD, HALT.
  - FETCH: pm_addr=PC; go to EXEC.
  - EXEC: pm_ins is valid; execute; normally return to FETCH.
  - MEMRD: A<=dm_rdata, PC<=PC+1, go to FETCH.
  - HALT: holds all state; exits only on Reset.
- Timing: 2 cycles per instruction; LDM takes 3.
- Opcodes:
  - 0 NOP
  - 1 LDI: A<=imm
  - 2 LDR: A<=R[n]
  - 3 STR: R[n]<=A; a write to R[NREGS-1] is ignored
  - 4 LDM: drive dm_addr, then MEMRD
  - 5 STM: dm_we=1 for exactly that EXEC cycle; dm_addr=addr
  - 6 ADD: {C,A}<=A+R[n]
  - 7 ADC: {C,A}<=A+R[n]+C
  - 8 SUB: A<=A-R[n]; C<=(A<R[n]) as borrow
  - 9 AND, A XOR: A<=A op R[n]; C unchanged
  - B JMP, C JZ (A==0), D JC (C==1): PC<=target if the condition holds, else PC+1
  - E CALL: push PC+1, PC<=target
  - F: opnd[0]=0 is RET (PC<=pop); opnd[0]=1 is HALT
- Arithmetic: modulo 2^DATA_W; carry is bit DATA_W of the (DATA_W+1)-bit sum.
- Every non-branching instruction sets PC<=PC+1 (wraps 2^PC_W-1 -> 0).
- CALL with SP==STACK_DEPTH: no push; PC<=PC+1; stack_err<=1.
- RET with SP==0: PC<=PC+1; stack_err<=1.
- stack_err is cleared only by Reset.
- dm_we is 0 in every state except an EXEC cycle executing STM.
- halted=1 exactly while state==HALT; pm_addr holds the HALT instruction's PC.

Optional Feature:
- Macro: ACC_CORE_STACK_EN.
- Defined: CALL/RET stack as specified.
- Undefined: no stack storage; CALL and RET execute as NOP (PC+1); stack_err tied to 0. The HALT encoding is unchanged.

Decomposition:
- Package acc_core_pkg holds:
  - opcode_e enum (4-bit)
  - state_e enum
  - localparams OPCODE_W=4 and OPND_W (function of DATA_W, PC_W)
  - helper function clog2
- Sub-module acc_call_stack (push/pop/full/empty, depth STACK_DEPTH, width PC_W) is instantiated only under ACC_CORE_STACK_EN.
- Register file stays inline.

Test Plan:
- Reset: assert Reset 3 cycles mid-LDM -> next cycle PC=0, A=0, dm_we=0, state FETCH; first pm_addr=0.
- Arithmetic: LDI 0xF0; STR R1; LDI 0x20; ADD R1 -> A=0x10, C=1; ADC R1 -> A=0x01, C=1; SUB R1 -> A=0x11, C=1.
- Memory/IO: in_port=0x5A; LDR R7; STM 3; LDI 0; LDM 3 -> dm_we high one cycle at addr 3 with data 0x5A; A=0x5A after MEMRD; LDM totals 3 cycles.
- Branch and wrap: LDI 0; JZ 0x20 -> PC=0x20. JC with C=0 -> PC+1. NOP at PC=63 -> PC=0.
- Stack: nested CALL x4 then RET x4 returns to each PC+1 in order. Fifth CALL -> stack_err=1, PC+1. RET on empty -> stack_err stays 1. Without ACC_CORE_STACK_EN, CALL acts as NOP.
- Halt: HALT at PC=5 -> halted=1, pm_addr stays 5, A frozen for 100 cycles; Reset -> halted=0, PC=0.

Source files
------------

// File: rtl/acc_core_pkg.sv
// acc_core_pkg: shared types and constants for the acc_core_p accumulator core.
// Optional call/return stack feature macro: ACC_CORE_STACK_EN.
package acc_core_pkg;

  localparam int OPCODE_W = 4;

  // Ceiling log2 of v (minimum 0); used for index and pointer widths.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Operand field width: wide enough for either an immediate or a jump target.
  function automatic int opnd_w(input int data_w, input int pc_w);
    return (data_w > pc_w) ? data_w : pc_w;
  endfunction

  localparam int OPND_W = opnd_w(8, 6);

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_LDR  = 4'h2,
    OP_STR  = 4'h3,
    OP_LDM  = 4'h4,
    OP_STM  = 4'h5,
    OP_ADD  = 4'h6,
    OP_ADC  = 4'h7,
    OP_SUB  = 4'h8,
    OP_AND  = 4'h9,
    OP_XOR  = 4'hA,
    OP_JMP  = 4'hB,
    OP_JZ   = 4'hC,
    OP_JC   = 4'hD,
    OP_CALL = 4'hE,
    OP_SYS  = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEMRD = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

endpackage

// File: rtl/acc_core_if.sv
// acc_core_if: program-memory and data-memory bus between acc_core_p (master)
// and the external synchronous PM/DM macros (slave).
// Optional call/return stack feature macro (core side): ACC_CORE_STACK_EN.
interface acc_core_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 6,
  parameter int DM_AW  = 4
);
  localparam int INS_W = acc_core_pkg::OPCODE_W + acc_core_pkg::opnd_w(DATA_W, PC_W);

  logic [PC_W-1:0]   pm_addr;
  logic [INS_W-1:0]  pm_ins;
  logic [DM_AW-1:0]  dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_we;
  logic [DATA_W-1:0] dm_rdata;

  modport master (
    output pm_addr, dm_addr, dm_wdata, dm_we,
    input  pm_ins, dm_rdata
  );

  modport slave (
    input  pm_addr, dm_addr, dm_wdata, dm_we,
    output pm_ins, dm_rdata
  );
endinterface

// File: rtl/acc_call_stack.sv
// acc_call_stack: LIFO of return addresses for CALL/RET.
// Only instantiated when ACC_CORE_STACK_EN is defined.
// Push on full and pop on empty are ignored here; the core flags them.
module acc_call_stack
  import acc_core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int SP_W = clog2(DEPTH + 1);
  localparam int AW   = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [W-1:0]    mem_q [DEPTH];
  logic [SP_W-1:0] sp_q;
  logic [AW-1:0]   wr_idx_s;
  logic [AW-1:0]   top_idx_s;

  assign wr_idx_s  = AW'(sp_q);
  assign top_idx_s = AW'(sp_q - SP_W'(1));
  assign full_o    = (sp_q == SP_W'(DEPTH));
  assign empty_o   = (sp_q == {SP_W{1'b0}});
  assign data_o    = mem_q[top_idx_s];

  // Stack pointer and entry storage; push has priority over pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q <= {SP_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
    end else if (push_i && !full_o) begin
      mem_q[wr_idx_s] <= data_i;
      sp_q            <= sp_q + SP_W'(1);
    end else if (pop_i && !empty_o) begin
      sp_q <= sp_q - SP_W'(1);
    end else begin
      sp_q <= sp_q;
    end
  end
endmodule

// File: rtl/acc_core_p.sv
// acc_core_p: multi-cycle accumulator core driving external synchronous PM/DM.
// FETCH -> EXEC (-> MEMRD for LDM) -> FETCH; HALT is left only by Reset.
// Optional feature macro: ACC_CORE_STACK_EN enables the CALL/RET stack;
// without it CALL/RET behave as NOP and stack_err stays 0.
module acc_core_p
  import acc_core_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PC_W        = 6,
  parameter int NREGS       = 8,
  parameter int DM_AW       = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              Reset,
  acc_core_if.master        bus,
  input  logic [DATA_W-1:0] in_port,
  output logic              halted,
  output logic              stack_err,
  output logic [PC_W-1:0]   pc_o,
  output logic [DATA_W-1:0] accu_o
);
  localparam int OW  = opnd_w(DATA_W, PC_W);
  localparam int RIW = clog2(NREGS);
  localparam logic [RIW-1:0] IN_REG = RIW'(NREGS - 1);

  state_e            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [DATA_W-1:0] a_q;
  logic              c_q;
  logic              err_q;
  logic [DATA_W-1:0] regs_q [NREGS];

  opcode_e           opc_s;
  logic [OW-1:0]     opnd_s;
  logic [RIW-1:0]    ridx_s;
  logic [PC_W-1:0]   tgt_s;
  logic [PC_W-1:0]   pc_inc_s;
  logic [DATA_W-1:0] rdat_s;
  logic [DATA_W:0]   sum_s;
  logic              exec_s;
  logic              is_ret_s;
  logic              is_halt_s;
  logic              err_set_s;

  logic [DATA_W-1:0] a_d;
  logic              c_d;
  logic [PC_W-1:0]   pc_d;
  state_e            exec_next_d;

  assign opc_s     = opcode_e'(bus.pm_ins[OW +: OPCODE_W]);
  assign opnd_s    = bus.pm_ins[OW-1:0];
  assign ridx_s    = opnd_s[RIW-1:0];
  assign tgt_s     = opnd_s[PC_W-1:0];
  assign pc_inc_s  = pc_q + PC_W'(1);
  assign exec_s    = (state_q == ST_EXEC);
  assign is_ret_s  = (opc_s == OP_SYS) && !opnd_s[0];
  assign is_halt_s = (opc_s == OP_SYS) && opnd_s[0];
  assign rdat_s    = (ridx_s == IN_REG) ? in_port : regs_q[ridx_s];

  // Memory-side outputs: PM address straight from the PC register, DM address
  // from the instruction being executed, write strobe only in EXEC of STM.
  assign bus.pm_addr  = pc_q;
  assign bus.dm_addr  = opnd_s[DM_AW-1:0];
  assign bus.dm_wdata = a_q;
  assign bus.dm_we    = exec_s && (opc_s == OP_STM);

  assign halted    = (state_q == ST_HALT);
  assign stack_err = err_q;
  assign pc_o      = pc_q;
  assign accu_o    = a_q;

`ifdef ACC_CORE_STACK_EN
  logic            push_s;
  logic            pop_s;
  logic            full_s;
  logic            empty_s;
  logic [PC_W-1:0] top_s;

  assign push_s    = exec_s && (opc_s == OP_CALL) && !full_s;
  assign pop_s     = exec_s && is_ret_s && !empty_s;
  assign err_set_s = exec_s && (((opc_s == OP_CALL) && full_s) || (is_ret_s && empty_s));

  acc_call_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_stack (
    .clk     (clk),
    .reset   (Reset),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  (pc_inc_s),
    .data_o  (top_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );
`else
  logic unused_stack_cfg_s;

  assign unused_stack_cfg_s = ^STACK_DEPTH;
  assign err_set_s          = 1'b0;
`endif

  // Execute-stage next values for A, C, PC and state, decoded from pm_ins.
  always_comb begin
    a_d         = a_q;
    c_d         = c_q;
    pc_d        = pc_inc_s;
    exec_next_d = ST_FETCH;
    sum_s       = {1'b0, a_q} + {1'b0, rdat_s}
                + {{DATA_W{1'b0}}, ((opc_s == OP_ADC) ? c_q : 1'b0)};
    case (opc_s)
      OP_NOP:  a_d = a_q;
      OP_LDI:  a_d = opnd_s[DATA_W-1:0];
      OP_LDR:  a_d = rdat_s;
      OP_STR:  a_d = a_q;
      OP_LDM:  exec_next_d = ST_MEMRD;
      OP_STM:  a_d = a_q;
      OP_ADD:  {c_d, a_d} = sum_s;
      OP_ADC:  {c_d, a_d} = sum_s;
      OP_SUB: begin
        a_d = a_q - rdat_s;
        c_d = (a_q < rdat_s);
      end
      OP_AND:  a_d = a_q & rdat_s;
      OP_XOR:  a_d = a_q ^ rdat_s;
      OP_JMP:  pc_d = tgt_s;
      OP_JZ:   pc_d = (a_q == {DATA_W{1'b0}}) ? tgt_s : pc_inc_s;
      OP_JC:   pc_d = c_q ? tgt_s : pc_inc_s;
      OP_CALL: begin
`ifdef ACC_CORE_STACK_EN
        pc_d = full_s ? pc_inc_s : tgt_s;
`else
        pc_d = pc_inc_s;
`endif
      end
      OP_SYS: begin
        if (is_halt_s) begin
          pc_d        = pc_q;
          exec_next_d = ST_HALT;
        end else begin
`ifdef ACC_CORE_STACK_EN
          pc_d = empty_s ? pc_inc_s : top_s;
`else
          pc_d = pc_inc_s;
`endif
        end
      end
      default: a_d = a_q;
    endcase
  end

  // Core FSM with architectural state (PC, A, C, register file, error flag).
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= ST_FETCH;
      pc_q    <= {PC_W{1'b0}};
      a_q     <= {DATA_W{1'b0}};
      c_q     <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      case (state_q)
        ST_FETCH: state_q <= ST_EXEC;
        ST_EXEC: begin
          state_q <= exec_next_d;
          pc_q    <= (exec_next_d == ST_MEMRD) ? pc_q : pc_d;
          a_q     <= a_d;
          c_q     <= c_d;
          if ((opc_s == OP_STR) && (ridx_s != IN_REG)) begin
            regs_q[ridx_s] <= a_q;
          end
          if (err_set_s) begin
            err_q <= 1'b1;
          end
        end
        ST_MEMRD: begin
          a_q     <= bus.dm_rdata;
          pc_q    <= pc_inc_s;
          state_q <= ST_FETCH;
        end
        ST_HALT:  state_q <= ST_HALT;
        default:  state_q <= ST_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_acc_core_p.sv
// tb_acc_core_p: directed-vector bench for acc_core_p with behavioural
// synchronous PM/DM models. Stack checks follow ACC_CORE_STACK_EN.
module tb_acc_core_p;
  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] in_port = 8'h00;
  logic       halted;
  logic       stack_err;
  logic [5:0] pc_o;
  logic [7:0] accu_o;

  logic [11:0] pm [64];
  logic [7:0]  dm [16];

  int n_checks = 0;
  int n_fail   = 0;

  acc_core_if #(.DATA_W(8), .PC_W(6), .DM_AW(4)) bus ();

  acc_core_p #(
    .DATA_W(8), .PC_W(6), .NREGS(8), .DM_AW(4), .STACK_DEPTH(4)
  ) dut (
    .clk       (clk),
    .Reset     (Reset),
    .bus       (bus.master),
    .in_port   (in_port),
    .halted    (halted),
    .stack_err (stack_err),
    .pc_o      (pc_o),
    .accu_o    (accu_o)
  );

  always #5 clk = ~clk;

  // Synchronous program memory: one-cycle read latency.
  always @(posedge clk) bus.pm_ins <= pm[bus.pm_addr];

  // Synchronous data memory: write on strobe, registered read.
  always @(posedge clk) begin
    if (bus.dm_we) dm[bus.dm_addr] <= bus.dm_wdata;
    bus.dm_rdata <= dm[bus.dm_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] enc(input logic [3:0] op, input logic [7:0] o);
    return {op, o};
  endfunction

  task automatic clr_pm();
    for (int i = 0; i < 64; i++) pm[i] = enc(4'hF, 8'h01);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; holds Reset for three rising edges.
  task automatic do_reset();
    Reset = 1'b1;
    step(3);
    Reset = 1'b0;
  endtask

  initial begin
    clr_pm();
    step(1);
    do_reset();
    chk("rst_pc", pc_o, 6'd0);
    chk("rst_a", accu_o, 8'h00);
    chk("rst_halted", halted, 1'b0);
    chk("rst_err", stack_err, 1'b0);
    chk("rst_dm_we", bus.dm_we, 1'b0);

    // Arithmetic and logic
    clr_pm();
    pm[0]    = enc(4'h1, 8'hF0);
    pm[1]    = enc(4'h3, 8'h01);
    pm[2]    = enc(4'h1, 8'h20);
    pm[3]    = enc(4'h6, 8'h01);
    pm[4]    = enc(4'h7, 8'h01);
    pm[5]    = enc(4'h8, 8'h01);
    pm[6]    = enc(4'hD, 8'h30);
    pm[6'h30] = enc(4'h9, 8'h01);
    pm[6'h31] = enc(4'hA, 8'h01);
    pm[6'h32] = enc(4'hD, 8'h3A);
    do_reset();
    step(8);
    chk("add_a", accu_o, 8'h10);
    step(2);
    chk("adc_a", accu_o, 8'h01);
    step(2);
    chk("sub_a", accu_o, 8'h11);
    step(2);
    chk("sub_borrow_jc", pc_o, 6'h30);
    step(2);
    chk("and_a", accu_o, 8'h10);
    step(2);
    chk("xor_a", accu_o, 8'hE0);
    step(2);
    chk("logic_keeps_c", pc_o, 6'h3A);

    // Memory and input port
    clr_pm();
    in_port = 8'h5A;
    pm[0] = enc(4'h2, 8'h07);
    pm[1] = enc(4'h5, 8'h03);
    pm[2] = enc(4'h1, 8'h00);
    pm[3] = enc(4'h4, 8'h03);
    do_reset();
    step(2);
    chk("ldr_in_port", accu_o, 8'h5A);
    step(1);
    chk("stm_we", bus.dm_we, 1'b1);
    chk("stm_addr", bus.dm_addr, 4'd3);
    chk("stm_data", bus.dm_wdata, 8'h5A);
    step(1);
    chk("stm_we_drop", bus.dm_we, 1'b0);
    chk("dm3_written", dm[3], 8'h5A);
    step(2);
    chk("ldi0_a", accu_o, 8'h00);
    step(2);
    chk("memrd_pc_hold", pc_o, 6'd3);
    step(1);
    chk("ldm_a", accu_o, 8'h5A);
    chk("ldm_pc", pc_o, 6'd4);

    // Reset in the middle of LDM (MEMRD would load 0x5A)
    clr_pm();
    pm[0] = enc(4'h1, 8'h77);
    pm[1] = enc(4'h4, 8'h03);
    do_reset();
    step(4);
    do_reset();
    chk("midldm_pc", pc_o, 6'd0);
    chk("midldm_a", accu_o, 8'h00);
    chk("midldm_we", bus.dm_we, 1'b0);
    chk("midldm_pm_addr", bus.pm_addr, 6'd0);
    step(2);
    chk("midldm_restart_a", accu_o, 8'h77);
    chk("midldm_restart_pc", pc_o, 6'd1);

    // Branches and PC wrap
    clr_pm();
    pm[0]     = enc(4'h1, 8'h00);
    pm[1]     = enc(4'hC, 8'h20);
    pm[6'h20] = enc(4'hD, 8'h10);
    pm[6'h21] = enc(4'hB, 8'h3F);
    pm[6'h3F] = enc(4'h0, 8'h00);
    do_reset();
    step(4);
    chk("jz_taken", pc_o, 6'h20);
    step(2);
    chk("jc_not_taken", pc_o, 6'h21);
    step(2);
    chk("jmp", pc_o, 6'h3F);
    step(2);
    chk("pc_wrap", pc_o, 6'h00);

    // Call/return stack
    clr_pm();
    pm[0]     = enc(4'hE, 8'h10);
    pm[1]     = enc(4'hF, 8'h00);
    pm[2]     = enc(4'hF, 8'h01);
    pm[6'h10] = enc(4'hE, 8'h20);
    pm[6'h20] = enc(4'hE, 8'h30);
    pm[6'h30] = enc(4'hE, 8'h38);
    pm[6'h38] = enc(4'hE, 8'h3C);
    pm[6'h39] = enc(4'hF, 8'h00);
    pm[6'h31] = enc(4'hF, 8'h00);
    pm[6'h21] = enc(4'hF, 8'h00);
    pm[6'h11] = enc(4'hF, 8'h00);
    do_reset();
`ifdef ACC_CORE_STACK_EN
    step(2); chk("call1", pc_o, 6'h10);
    step(2); chk("call2", pc_o, 6'h20);
    step(2); chk("call3", pc_o, 6'h30);
    step(2); chk("call4", pc_o, 6'h38);
    chk("call4_no_err", stack_err, 1'b0);
    step(2); chk("call5_pc", pc_o, 6'h39);
    chk("call5_err", stack_err, 1'b1);
    step(2); chk("ret1", pc_o, 6'h31);
    step(2); chk("ret2", pc_o, 6'h21);
    step(2); chk("ret3", pc_o, 6'h11);
    step(2); chk("ret4", pc_o, 6'h01);
    step(2); chk("ret_empty_pc", pc_o, 6'h02);
    chk("ret_empty_err", stack_err, 1'b1);
`else
    step(2); chk("call_nop_pc", pc_o, 6'h01);
    step(2); chk("ret_nop_pc", pc_o, 6'h02);
    chk("nostack_err", stack_err, 1'b0);
`endif

    // HALT at PC=5
    clr_pm();
    pm[0] = enc(4'h1, 8'h33);
    for (int i = 1; i < 5; i++) pm[i] = enc(4'h0, 8'h00);
    pm[5] = enc(4'hF, 8'h01);
    do_reset();
    step(12);
    chk("halt_flag", halted, 1'b1);
    chk("halt_pc", pc_o, 6'd5);
    step(100);
    chk("halt_hold_flag", halted, 1'b1);
    chk("halt_hold_pm_addr", bus.pm_addr, 6'd5);
    chk("halt_hold_a", accu_o, 8'h33);
    chk("halt_hold_we", bus.dm_we, 1'b0);
    do_reset();
    chk("halt_reset_flag", halted, 1'b0);
    chk("halt_reset_pc", pc_o, 6'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
